// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI requester arbiter.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int id_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search upward from last_grant+1, wrapping.
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = last_grant;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (idx == ID_W'(NUM_REQ - 1)) idx = '0;
      else                           idx = idx + 1'b1;
      if (!any && req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one spi_master between NUM_REQ requesters: round-robin grant,
// single outstanding transfer, timeout error response, idle gap after each response.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_LENGTH = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT     = 1024,
  localparam int ID_W = id_width(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic                           resp_valid,
  output logic [ID_W-1:0]                resp_id,
  output logic [DATA_LENGTH-1:0]         resp_data,
  output logic                           resp_err,
  output logic                           m_start,
  output logic [DATA_LENGTH-1:0]         m_data_in,
  input  logic                           m_done,
  input  logic [DATA_LENGTH-1:0]         m_data_out,
  output logic [ID_W-1:0]                slave_sel,
  output logic                           arb_busy
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int GW = id_width(GAP_CYCLES + 1);
  // With no gap configured the response edge returns straight to IDLE.
  localparam arb_state_t POST_RESP = (GAP_CYCLES == 0) ? IDLE : GAP;

  arb_state_t             state, state_nxt;
  logic [ID_W-1:0]        last_grant, winner;
  logic                   any;
  logic [TW-1:0]          timer;
  logic [GW-1:0]          gap_cnt;
  logic                   to_hit;
  logic [DATA_LENGTH-1:0] win_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .any        (any)
  );

  assign to_hit = (timer == TW'(TIMEOUT - 1));

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (winner == ID_W'(i)) win_data = req_data[i*DATA_LENGTH +: DATA_LENGTH];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (m_done || to_hit) state_nxt = POST_RESP;
      GAP:     if (gap_cnt == GW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      timer      <= '0;
      gap_cnt    <= '0;
      req_ack    <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      m_start    <= 1'b0;
      m_data_in  <= '0;
      slave_sel  <= '0;
      arb_busy   <= 1'b0;
    end else begin
      state      <= state_nxt;
      arb_busy   <= (state_nxt != IDLE);
      req_ack    <= '0;
      m_start    <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            m_start    <= 1'b1;
            m_data_in  <= win_data;
            req_ack    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
            slave_sel  <= winner;
            last_grant <= winner;
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          if (timer != '1) timer <= timer + 1'b1;
          // A done pulse on the timeout cycle still yields a normal response.
          if (m_done) begin
            resp_valid <= 1'b1;
            resp_data  <= m_data_out;
            resp_id    <= slave_sel;
            resp_err   <= 1'b0;
            gap_cnt    <= GW'(GAP_CYCLES);
          end else if (to_hit) begin
            resp_valid <= 1'b1;
            resp_data  <= '0;
            resp_id    <= slave_sel;
            resp_err   <= 1'b1;
            gap_cnt    <= GW'(GAP_CYCLES);
          end
        end
        GAP: gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: vector table plus scoreboarded responses.
module tb_spi_arbiter;

  localparam int N  = 4;
  localparam int DL = 8;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT with a 2-cycle gap, driven by the loopback slave model
  logic [N-1:0]    req_valid = '0;
  logic [N*DL-1:0] req_data  = '0;
  logic [N-1:0]    req_ack;
  logic            resp_valid, resp_err, m_start, arb_busy;
  logic [1:0]      resp_id, slave_sel;
  logic [DL-1:0]   resp_data, m_data_in;
  logic [DL-1:0]   m_data_out = '0;
  logic            s_done = 1'b0, spur_done = 1'b0;
  logic            m_done;
  assign m_done = s_done | spur_done;

  // DUT with no gap, m_done driven by hand
  logic [N-1:0]    req_valid0 = '0;
  logic [N*DL-1:0] req_data0  = '0;
  logic [N-1:0]    req_ack0;
  logic            resp_valid0, resp_err0, m_start0, arb_busy0;
  logic [1:0]      resp_id0, slave_sel0;
  logic [DL-1:0]   resp_data0, m_data_in0;
  logic [DL-1:0]   m_data_out0 = '0;
  logic            m_done0 = 1'b0;

  spi_arbiter #(.NUM_REQ(N), .DATA_LENGTH(DL), .GAP_CYCLES(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .m_start(m_start), .m_data_in(m_data_in), .m_done(m_done), .m_data_out(m_data_out),
    .slave_sel(slave_sel), .arb_busy(arb_busy)
  );

  spi_arbiter #(.NUM_REQ(N), .DATA_LENGTH(DL), .GAP_CYCLES(0), .TIMEOUT(TO)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_data(req_data0), .req_ack(req_ack0),
    .resp_valid(resp_valid0), .resp_id(resp_id0), .resp_data(resp_data0), .resp_err(resp_err0),
    .m_start(m_start0), .m_data_in(m_data_in0), .m_done(m_done0), .m_data_out(m_data_out0),
    .slave_sel(slave_sel0), .arb_busy(arb_busy0)
  );

  int nchecks = 0;
  int nerr    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] outs();
    return {req_ack, resp_valid, resp_id, resp_data, resp_err, m_start, m_data_in, slave_sel, arb_busy};
  endfunction

  // Loopback slave: answers 3 cycles after m_start with tx ^ 0x99
  bit          slave_en = 1'b1;
  int unsigned s_cnt = 0;
  logic [7:0]  s_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      s_cnt  = 0;
      s_done = 1'b0;
    end else begin
      if (s_done) s_done = 1'b0;
      if (s_cnt > 0) begin
        s_cnt--;
        if (s_cnt == 0) begin
          s_done     = 1'b1;
          m_data_out = s_data;
        end
      end
      if (m_start && slave_en) begin
        s_cnt  = 3;
        s_data = m_data_in ^ 8'h99;
      end
    end
  end

  // Scoreboard of expected responses
  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       err;
  } resp_t;
  resp_t sb[$];
  resp_t e;
  logic       prev_rv = 1'b0;
  logic [7:0] held    = '0;

  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        nchecks++;
        nerr++;
        $display("FAIL resp_unexpected: got id=%0d data=0x%0h err=%0b with empty scoreboard",
                 resp_id, resp_data, resp_err);
      end else begin
        e = sb.pop_front();
        check("resp_id", resp_id, e.id);
        check("resp_data", resp_data, e.data);
        check("resp_err", resp_err, e.err);
      end
    end else if (prev_rv && !rst) begin
      check("resp_hold", resp_data, held);
    end
    prev_rv = resp_valid;
    held    = resp_data;
  end

  task automatic set_data(input int exp, input logic [7:0] wd);
    for (int i = 0; i < N; i++)
      req_data[i*DL +: DL] = (i == exp) ? wd : (8'hE0 | 8'(i));
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (|req_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      nchecks++;
      nerr++;
      $display("FAIL ack_timeout: req_ack=0 expected a grant within 100 cycles");
    end
  endtask

  task automatic do_xfer(input logic [3:0] mask, input int exp, input logic [7:0] wd,
                         input logic [3:0] after, input bit to_err);
    bit ok;
    req_valid = mask;
    set_data(exp, wd);
    wait_ack(ok);
    if (ok) begin
      check("req_ack", req_ack, 32'(1) << exp);
      check("m_start", m_start, 1);
      check("m_data_in", m_data_in, wd);
      check("slave_sel", slave_sel, exp);
      sb.push_back('{id: 2'(exp), data: (to_err ? 8'h00 : (wd ^ 8'h99)), err: to_err});
      req_valid = after;
      @(negedge clk);
      check("ack_pulse", req_ack, 0);
      check("m_start_pulse", m_start, 0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !arb_busy) return;
      @(negedge clk);
    end
    nchecks++;
    nerr++;
    $display("FAIL drain_timeout: %0d responses outstanding, arb_busy=%0b expected 0 and 0",
             sb.size(), arb_busy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    bit         rst_first;
    logic [3:0] mask;
    int         exp;
    logic [7:0] wd;
  } vec_t;
  vec_t vt[13];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit         ok;
    int         n;
    logic [3:0] after;

    vt[0]  = '{1'b1, 4'b0001, 0, 8'hA5};
    vt[1]  = '{1'b1, 4'b1111, 0, 8'h10};
    vt[2]  = '{1'b0, 4'b1111, 1, 8'h21};
    vt[3]  = '{1'b0, 4'b1111, 2, 8'h32};
    vt[4]  = '{1'b0, 4'b1111, 3, 8'h43};
    vt[5]  = '{1'b0, 4'b1111, 0, 8'h54};
    vt[6]  = '{1'b1, 4'b0101, 0, 8'h65};
    vt[7]  = '{1'b0, 4'b0101, 2, 8'h76};
    vt[8]  = '{1'b0, 4'b0101, 0, 8'h87};
    vt[9]  = '{1'b0, 4'b0101, 2, 8'h98};
    vt[10] = '{1'b0, 4'b1000, 3, 8'hA9};
    vt[11] = '{1'b0, 4'b0110, 1, 8'hBA};
    vt[12] = '{1'b0, 4'b0110, 2, 8'hCB};

    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(outs()), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_not_busy", arb_busy, 0);

    for (int v = 0; v < 13; v++) begin
      if (vt[v].rst_first) begin
        req_valid = '0;
        drain();
        do_reset();
      end
      after = (v < 12 && !vt[v+1].rst_first) ? vt[v+1].mask : 4'b0000;
      do_xfer(vt[v].mask, vt[v].exp, vt[v].wd, after, 1'b0);
    end
    drain();

    // Timeout: silent slave, error response TO cycles after WAIT entry
    slave_en = 1'b0;
    do_xfer(4'b0100, 2, 8'h5E, 4'b0000, 1'b1);
    n = 1;
    while (n < TO + 10 && !resp_valid) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, TO + 1);
    drain();
    slave_en = 1'b1;
    do_xfer(4'b0001, 0, 8'h11, 4'b0000, 1'b0);
    drain();

    // Gap of 2 idle cycles after a response, with a spurious done inside it
    do_xfer(4'b1000, 3, 8'h42, 4'b1000, 1'b0);
    n = 0;
    while (n < 50 && !resp_valid) begin
      @(negedge clk);
      n++;
    end
    check("gap_resp_seen", resp_valid, 1);
    check("gap_busy_t0", arb_busy, 1);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check("gap_busy_t1", arb_busy, 1);
    check("spur_gap_rv", resp_valid, 0);
    @(negedge clk);
    check("gap_idle_t2", arb_busy, 0);
    check("gap_no_start_t2", m_start, 0);
    @(negedge clk);
    check("gap_restart", m_start, 1);
    check("gap_restart_ack", req_ack, 4'b1000);
    sb.push_back('{id: 2'd3, data: 8'h42 ^ 8'h99, err: 1'b0});
    req_valid = '0;
    drain();

    // Spurious done while idle
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check("spur_idle_rv", resp_valid, 0);
    check("spur_idle_busy", arb_busy, 0);
    @(negedge clk);
    check("spur_idle_busy2", arb_busy, 0);

    // Reset in the middle of WAIT aborts without a response
    req_valid = 4'b0010;
    set_data(1, 8'h77);
    wait_ack(ok);
    check("rst_pre_ack", req_ack, 4'b0010);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_wait_outputs", 32'(outs()), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_xfer(4'b0101, 0, 8'h5A, 4'b0000, 1'b0);
    drain();

    // No-gap instance: response cycle is already idle, next start follows at once
    req_valid0 = 4'b0001;
    req_data0  = {24'h0, 8'h21};
    n = 0;
    while (n < 50 && !m_start0) begin
      @(negedge clk);
      n++;
    end
    check("g0_m_start", m_start0, 1);
    check("g0_m_data_in", m_data_in0, 8'h21);
    repeat (2) @(negedge clk);
    m_done0     = 1'b1;
    m_data_out0 = 8'h6B;
    @(negedge clk);
    m_done0 = 1'b0;
    check("g0_resp_valid", resp_valid0, 1);
    check("g0_resp_data", resp_data0, 8'h6B);
    check("g0_resp_id", resp_id0, 0);
    check("g0_busy_at_resp", arb_busy0, 0);
    @(negedge clk);
    check("g0_restart", m_start0, 1);
    req_valid0 = '0;
    @(negedge clk);

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one spi_master; must be at least 2.
REQ-002 Parameter DATA_LENGTH, default 8: transfer word width; equals the spi_master DATA_LENGTH.
REQ-003 Parameter GAP_CYCLES, default 2: minimum idle clk cycles between a response and the next m_start; 0 is legal.
REQ-004 Parameter TIMEOUT, default 1024: clk cycles allowed in WAIT before an error response.
REQ-005 Derived constant ID_W = max(1, clog2(NUM_REQ)).
REQ-006 clk  in  1  single clock; all logic is rising-edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 req_valid  in  NUM_REQ  per-requester transfer request.
REQ-009 req_data  in  NUM_REQ*DATA_LENGTH  TX word; requester i occupies slice [i*DATA_LENGTH +: DATA_LENGTH].
REQ-010 req_ack  out  NUM_REQ  one-cycle pulse; the request has been taken.
REQ-011 resp_valid  out  1  one-cycle pulse; the response fields are valid.
REQ-012 resp_id  out  ID_W  index of the requester being answered.
REQ-013 resp_data  out  DATA_LENGTH  RX word.
REQ-014 resp_err  out  1  set when the transfer timed out.
REQ-015 m_start  out  1  start pulse to spi_master.
REQ-016 m_data_in  out  DATA_LENGTH  TX word to spi_master.
REQ-017 m_done  in  1  spi_master done pulse.
REQ-018 m_data_out  in  DATA_LENGTH  spi_master RX word; valid when m_done is high.
REQ-019 slave_sel  out  ID_W  granted index, used for the external chip-select decode.
REQ-020 arb_busy  out  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, ISSUE, WAIT and GAP; every output SHALL be registered.
REQ-022 In IDLE, the FSM SHALL select the winner only if at least one req_valid bit is high; selection is round-robin, searching from last_grant+1 upward with wrap from NUM_REQ-1 to 0.
REQ-023 IDLE→ISSUE edge: m_start<=1, m_data_in<=winner's slice, req_ack[w]<=1, slave_sel<=w, last_grant<=w.
REQ-024 ISSUE SHALL last exactly 1 cycle; ISSUE→WAIT edge: m_start<=0, req_ack<=0, timer<=0.
REQ-025 A requester SHALL hold req_valid and req_data stable until req_ack; dropping req_valid before the decision edge removes that requester from arbitration.
REQ-026 WAIT: timer increments each cycle; m_done high SHALL cause resp_data<=m_data_out, resp_id<=slave_sel, resp_err<=0, resp_valid<=1, then a move to GAP.
REQ-027 WAIT: if timer==TIMEOUT-1 and m_done is low, the FSM SHALL set resp_valid<=1, resp_err<=1, resp_data<=0, then move to GAP; if m_done arrives in that same cycle, the done response wins.
REQ-028 resp_valid SHALL clear on the next edge; resp_data, resp_id and resp_err SHALL hold until the next response.
REQ-029 GAP: the gap counter is loaded with GAP_CYCLES on entry and decrements each cycle; the FSM goes to IDLE when the counter reads 1. With GAP_CYCLES=0, WAIT goes directly to IDLE.
REQ-030 m_done while in IDLE, ISSUE or GAP SHALL be ignored.
REQ-031 The timer SHALL be clog2(TIMEOUT)+1 bits wide, saturating; the gap counter is clog2(GAP_CYCLES+1) bits wide (minimum 1).
REQ-032 At most one req_ack bit SHALL be high in any cycle, and at most one transfer SHALL be outstanding.

Reset
REQ-033 On rst: state=IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first), all counters=0, and every output=0.
REQ-034 rst in any state, including mid-WAIT, SHALL abort the transfer without issuing a response.

Structure
REQ-035 Shared package spi_pkg SHALL hold arb_state_t {IDLE, ISSUE, WAIT, GAP} (2-bit) and the ID_W helper function.
REQ-036 The round-robin selection SHALL be one combinational sub-module, rr_arbiter (inputs: req, last_grant; outputs: winner, any).

Verification
REQ-037 Scenario: req 0 with 0xA5, loopback slave returns 0x3C -> req_ack[0] pulses 1 cycle; m_start pulses once with m_data_in=0xA5; resp_valid with resp_id=0, resp_data=0x3C, resp_err=0.
REQ-038 Scenario: all four req_valid high from reset -> grant order 0,1,2,3,0; then only req 0 and req 2 held -> grants alternate 0,2,0,2.
REQ-039 Scenario: m_done never asserted -> resp_err=1 and resp_data=0 exactly TIMEOUT cycles after WAIT entry; the next request is served afterwards.
REQ-040 Scenario: back-to-back requests with GAP_CYCLES=2 -> exactly 2 cycles of GAP between the resp_valid cycle and return to IDLE; repeat with GAP_CYCLES=0 -> no GAP state.
REQ-041 Scenario: rst mid-WAIT -> all outputs return to 0 with no resp_valid; the first post-reset grant goes to requester 0.
REQ-042 Scenario: spurious m_done in IDLE and in GAP -> no resp_valid and no state change.
